// File: rtl/march_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : march_bist_ctrl_if
// Description : Control and status bundle of the March C- BIST controller.
// Revision    : 1.0
// ============================================================================
interface march_bist_ctrl_if #(
  parameter int Dta_size = 8,
  parameter int Adr_size = 4
);
  logic                start;
  logic [Adr_size-1:0] adress;
  logic                wr_en;
  logic                read_en;
  logic                busy;
  logic                done;
  logic                fail;
  logic [Adr_size-1:0] fail_adress;
  logic [Dta_size-1:0] fail_data;
  logic [2:0]          fail_elem;

  modport master (
    input  start,
    output adress, wr_en, read_en, busy, done, fail,
    output fail_adress, fail_data, fail_elem
  );

  modport slave (
    output start,
    input  adress, wr_en, read_en, busy, done, fail,
    input  fail_adress, fail_data, fail_elem
  );
endinterface : march_bist_ctrl_if
`default_nettype wire

// File: rtl/march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : march_bist_ctrl
// Description : March C- BIST controller for a single-port tri-state RAM.
// Revision    : 1.0
// ============================================================================
module march_bist_ctrl #(
  parameter int Dta_size = 8,
  parameter int Adr_size = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  march_bist_ctrl_if.master     bus,
  inout  wire [Dta_size-1:0]    data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_E1   = 3'd2,
    S_E2   = 3'd3,
    S_E3   = 3'd4,
    S_E4   = 3'd5,
    S_E5   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [Adr_size-1:0] c_adr_max = {Adr_size{1'b1}};
  localparam logic [Dta_size-1:0] c_ones    = {Dta_size{1'b1}};

  state_t              state_q;
  logic                phase_q;
  logic [Adr_size-1:0] adress_q;
  logic                wr_en_q;
  logic                read_en_q;
  logic [Dta_size-1:0] wr_data_q;
  logic                busy_q;
  logic                done_q;
  logic                fail_q;
  logic [Adr_size-1:0] fail_adress_q;
  logic [Dta_size-1:0] fail_data_q;
  logic [2:0]          fail_elem_q;
  logic                w_miscompare;

  function automatic logic is_down(input state_t s);
    return (s == S_E3) || (s == S_E4);
  endfunction

  function automatic logic has_write_phase(input state_t s);
    return (s == S_E1) || (s == S_E2) || (s == S_E3) || (s == S_E4);
  endfunction

  function automatic logic [Dta_size-1:0] exp_pat(input state_t s);
    return ((s == S_E2) || (s == S_E4)) ? c_ones : '0;
  endfunction

  function automatic logic [Dta_size-1:0] wr_pat(input state_t s);
    return ((s == S_E1) || (s == S_E3)) ? c_ones : '0;
  endfunction

  // States E0..E5 are encoded 1..6, so the element index is one less.
  function automatic logic [2:0] elem_idx(input state_t s);
    return 3'(s) - 3'd1;
  endfunction

  function automatic logic [Adr_size-1:0] first_adr(input state_t s);
    return is_down(s) ? c_adr_max : '0;
  endfunction

  function automatic logic [Adr_size-1:0] last_adr(input state_t s);
    return is_down(s) ? '0 : c_adr_max;
  endfunction

  // Case-inequality so an undriven or unknown read bit is reported as a fault.
  always_comb begin
    w_miscompare = 1'b0;
    if (read_en_q && (data !== exp_pat(state_q))) begin
      w_miscompare = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      adress_q      <= '0;
      wr_en_q       <= 1'b0;
      read_en_q     <= 1'b0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_adress_q <= '0;
      fail_data_q   <= '0;
      fail_elem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q       <= S_E0;
            phase_q       <= 1'b0;
            adress_q      <= '0;
            wr_en_q       <= 1'b1;
            read_en_q     <= 1'b0;
            wr_data_q     <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_adress_q <= '0;
            fail_data_q   <= '0;
            fail_elem_q   <= '0;
          end
        end
        default: begin
          if (w_miscompare) begin
            fail_q        <= 1'b1;
            fail_adress_q <= adress_q;
            fail_data_q   <= data;
            fail_elem_q   <= elem_idx(state_q);
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_DONE;
            phase_q       <= 1'b0;
            adress_q      <= '0;
            wr_en_q       <= 1'b0;
            read_en_q     <= 1'b0;
          end else if (has_write_phase(state_q) && !phase_q) begin
            phase_q   <= 1'b1;
            read_en_q <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_data_q <= wr_pat(state_q);
          end else if (adress_q == last_adr(state_q)) begin
            phase_q <= 1'b0;
            if (state_q == S_E5) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              adress_q  <= '0;
              wr_en_q   <= 1'b0;
              read_en_q <= 1'b0;
            end else begin
              // Every element after E0 opens with a read.
              state_q   <= state_t'(3'(state_q) + 3'd1);
              adress_q  <= first_adr(state_t'(3'(state_q) + 3'd1));
              wr_en_q   <= 1'b0;
              read_en_q <= 1'b1;
            end
          end else begin
            phase_q  <= 1'b0;
            adress_q <= is_down(state_q) ? (adress_q - 1'b1) : (adress_q + 1'b1);
            if (state_q == S_E0) begin
              wr_en_q   <= 1'b1;
              read_en_q <= 1'b0;
            end else begin
              wr_en_q   <= 1'b0;
              read_en_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign data            = wr_en_q ? wr_data_q : {Dta_size{1'bz}};
  assign bus.adress      = adress_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.read_en     = read_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fail        = fail_q;
  assign bus.fail_adress = fail_adress_q;
  assign bus.fail_data   = fail_data_q;
  assign bus.fail_elem   = fail_elem_q;

endmodule : march_bist_ctrl
`default_nettype wire
